// File: rtl/spike_rate_decoder_if.sv
// spike_rate_decoder_if
//   Valid/ready result channel from the spike rate decoder to a downstream
//   logger or host.
//   rate       spike count of the last accepted window
//   out_valid  rate holds an unconsumed result
//   out_ready  downstream accepts rate when out_valid & out_ready
interface spike_rate_decoder_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] rate;
    logic             out_valid;
    logic             out_ready;

    modport master (output rate, output out_valid, input out_ready);
    modport slave  (input rate, input out_valid, output out_ready);
endinterface

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//   Turns a 1-bit spike train back into numbers. Counts spikes over a
//   programmable window (rate code, sent through a valid/ready channel) and
//   measures the inter-spike interval between the two most recent spikes.
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         decode enable; low = idle, partial window discarded
//   spike      spike input, one sample per cycle
//   window     window length in cycles, latched at each window start; 0 = 2**CNT_W
//   clr        synchronous clear of overflow
//   out_if     result channel (rate, out_valid, out_ready)
//   overflow   sticky: a completed window was dropped
//   isi        cycles between the two most recent spikes (saturating)
//   isi_valid  isi holds a real interval
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | decoder disabled, counters cleared; an en=1 cycle here is
//         | already the first sample of a window, taken with the live
//         | window input
// ST_RUN  | windows running back-to-back using the latched window length
module spike_rate_decoder #(
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    spike,
    input  logic [CNT_W-1:0]        window,
    input  logic                    clr,
    spike_rate_decoder_if.master    out_if,
    output logic                    overflow,
    output logic [CNT_W-1:0]        isi,
    output logic                    isi_valid
);

    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] win_q;
    logic [CNT_W-1:0] wcnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] icnt;
    logic             armed;

    logic [CNT_W-1:0] win_eff;
    logic             last;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] cnt_sat;
    logic [CNT_W-1:0] icnt_inc;
    logic             result_ev;
    logic             load;
    logic             drop;

    always_comb begin
        state_nxt = state;
        win_eff   = win_q;
        case (state)
            ST_IDLE: begin
                win_eff = window;
                if (en) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!en) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A window length of 0 wraps to MAX here, giving the full 2**CNT_W cycles.
    assign last      = (wcnt == (win_eff - ONE));
    assign sum       = {1'b0, cnt} + {{CNT_W{1'b0}}, spike};
    assign cnt_sat   = sum[CNT_W] ? MAX : sum[CNT_W-1:0];
    assign icnt_inc  = (icnt == MAX) ? MAX : (icnt + ONE);
    assign result_ev = en && last;
    assign load      = result_ev && (!out_if.out_valid || out_if.out_ready);
    assign drop      = result_ev && out_if.out_valid && !out_if.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            win_q            <= '0;
            wcnt             <= '0;
            cnt              <= '0;
            icnt             <= '0;
            armed            <= 1'b0;
            isi              <= '0;
            isi_valid        <= 1'b0;
            out_if.rate      <= '0;
            out_if.out_valid <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            state <= state_nxt;

            if (!en) begin
                wcnt      <= '0;
                cnt       <= '0;
                icnt      <= '0;
                armed     <= 1'b0;
                isi_valid <= 1'b0;
            end else begin
                if (state == ST_IDLE || last) win_q <= window;
                if (last) begin
                    wcnt <= '0;
                    cnt  <= '0;
                end else begin
                    wcnt <= wcnt + ONE;
                    cnt  <= cnt_sat;
                end

                // The first spike after enable only arms the interval counter.
                if (spike) begin
                    icnt  <= ONE;
                    armed <= 1'b1;
                    if (armed) begin
                        isi       <= icnt;
                        isi_valid <= 1'b1;
                    end
                end else begin
                    icnt <= icnt_inc;
                end
            end

            if (load) begin
                out_if.rate      <= cnt_sat;
                out_if.out_valid <= 1'b1;
            end else if (out_if.out_ready) begin
                out_if.out_valid <= 1'b0;
            end

            if (drop)     overflow <= 1'b1;
            else if (clr) overflow <= 1'b0;
        end
    end

endmodule
